// File: rtl/uart_transmitter.sv
// UART transmitter with TX FIFO, optional parity and 16x-oversampled bit timing.
// Define UART_TX_TWO_STOP_EN for two stop bits (32 ticks of STOP).
module uart_transmitter #(
  parameter int unsigned FIFOLENGTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bclk,
  input  logic       write_en,
  input  logic [7:0] data_in,
  input  logic       tx_en,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic [1:0] tx_thr_val,
  output logic       txd,
  output logic       tx_bclk_en,
  output logic       tx_full,
  output logic       tx_empty,
  output logic       tx_ov,
  output logic       tx_thr
);

  localparam int unsigned AW = $clog2(FIFOLENGTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mem [FIFOLENGTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        push, pop;
  logic [7:0]  data_q;
  logic        par_en_q, par_odd_q, par_bit;
  logic [3:0]  tick_cnt, tick_nxt;
  logic [2:0]  bit_idx, bit_nxt, bit_inc;
  logic        txd_nxt;
  logic        last_tick, stop_last, can_start;
  int unsigned thr_lvl;

  assign count    = wr_ptr - rd_ptr;
  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push     = write_en && !tx_full;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

  always_comb begin
    thr_lvl = 0;
    case (tx_thr_val)
      2'd0: thr_lvl = 0;
      2'd1: thr_lvl = 2;
      2'd2: thr_lvl = 4;
      default: thr_lvl = 8;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      tx_ov  <= 1'b0;
      tx_thr <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      tx_ov  <= write_en && tx_full;
      tx_thr <= (32'(count) <= thr_lvl);
    end
  end

  assign tx_bclk_en = (state != IDLE);
  assign last_tick  = bclk && (tick_cnt == 4'd15);
  assign can_start  = tx_en && !tx_empty;
  assign bit_inc    = bit_idx + 3'd1;
  assign par_bit    = par_odd_q ? ~^data_q : ^data_q;

`ifdef UART_TX_TWO_STOP_EN
  assign stop_last = bit_idx[0];
`else
  assign stop_last = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_idx;
    txd_nxt   = txd;
    pop       = 1'b0;
    // Tick counter wraps naturally; every bit boundary lands on 15 -> 0.
    if (state != IDLE && bclk) tick_nxt = tick_cnt + 4'd1;
    case (state)
      IDLE: begin
        txd_nxt = 1'b1;
        if (can_start) begin
          state_nxt = START;
          pop       = 1'b1;
          txd_nxt   = 1'b0;
          tick_nxt  = '0;
          bit_nxt   = '0;
        end
      end
      START: begin
        if (last_tick) begin
          state_nxt = DATA;
          txd_nxt   = data_q[0];
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (last_tick) begin
          if (bit_idx == 3'd7) begin
            bit_nxt = '0;
            if (par_en_q) begin
              state_nxt = PARITY;
              txd_nxt   = par_bit;
            end else begin
              state_nxt = STOP;
              txd_nxt   = 1'b1;
            end
          end else begin
            bit_nxt = bit_inc;
            txd_nxt = data_q[bit_inc];
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          state_nxt = STOP;
          txd_nxt   = 1'b1;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        if (last_tick) begin
          // bit_idx counts stop bits here so two-stop mode reuses the same counter.
          if (!stop_last) begin
            bit_nxt = bit_inc;
          end else if (can_start) begin
            state_nxt = START;
            pop       = 1'b1;
            txd_nxt   = 1'b0;
            bit_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            bit_nxt   = '0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      txd       <= 1'b1;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_idx  <= bit_nxt;
      txd      <= txd_nxt;
      if (pop) begin
        data_q    <= mem[rd_ptr[AW-1:0]];
        par_en_q  <= parity_en;
        par_odd_q <= parity_type;
      end
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: scoreboard of queued bytes decoded
// cycle by cycle from txd against a bench-side tick model.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       reset, bclk, write_en, tx_en, parity_en, parity_type;
  logic [7:0] data_in;
  logic [1:0] tx_thr_val;
  logic       txd, tx_bclk_en, tx_full, tx_empty, tx_ov, tx_thr;

  uart_transmitter #(.FIFOLENGTH(16)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .write_en(write_en), .data_in(data_in),
    .tx_en(tx_en), .parity_en(parity_en), .parity_type(parity_type), .tx_thr_val(tx_thr_val),
    .txd(txd), .tx_bclk_en(tx_bclk_en), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_ov(tx_ov), .tx_thr(tx_thr)
  );

  always #5 clk = ~clk;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  typedef struct {logic [7:0] data; logic pen; logic podd;} frame_t;
  frame_t sb[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic push_byte(input logic [7:0] d);
    write_en = 1'b1;
    data_in  = d;
    @(negedge clk);
    write_en = 1'b0;
    sb.push_back('{d, parity_en, parity_type});
  endtask

  // action: 1 = flip parity settings mid-frame, 2 = drop tx_en mid-frame, 3 = stall bclk 20 cycles
  task automatic recv_frame(input string tag, input int action, output int wait_cyc,
                            output int nsamp, output logic thr0, output logic thr1);
    frame_t     f;
    logic [11:0] expb, seen0, seen1;
    int         nbits, t, bcnt;
    logic       b;
    wait_cyc = 0;
    nsamp = 0;
    thr0 = 1'bx;
    thr1 = 1'bx;
    while (txd !== 1'b0 && wait_cyc < 400) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (txd !== 1'b0) begin
      check({tag, "_start_timeout"}, 32'(txd), 32'd0);
      return;
    end
    if (sb.size() == 0) begin
      check({tag, "_unexpected_frame"}, 32'(sb.size()), 32'd1);
      return;
    end
    f = sb.pop_front();
    expb = '0;
    expb[0] = 1'b0;
    for (int i = 0; i < 8; i++) expb[i+1] = f.data[i];
    nbits = 9;
    if (f.pen) begin
      expb[nbits] = f.podd ? ~^f.data : ^f.data;
      nbits++;
    end
    for (int i = 0; i < NSTOP; i++) begin
      expb[nbits] = 1'b1;
      nbits++;
    end
    seen0 = '0;
    seen1 = '0;
    t = 0;
    bcnt = 0;
    while (t < nbits * 16 && nsamp < 3000) begin
      if (txd === 1'b1) seen1[t/16] = 1'b1;
      else seen0[t/16] = 1'b1;
      if (tx_bclk_en === 1'b1) bcnt++;
      if (nsamp == 0) thr0 = tx_thr;
      if (nsamp == 1) thr1 = tx_thr;
      if (nsamp == 40) begin
        case (action)
          1: begin parity_type = ~parity_type; parity_en = ~parity_en; end
          2: tx_en = 1'b0;
          3: bclk = 1'b0;
          default: ;
        endcase
      end
      if (nsamp == 60 && action == 3) bclk = 1'b1;
      b = bclk;
      @(negedge clk);
      if (b) t++;
      nsamp++;
    end
    for (int p = 0; p < nbits; p++)
      check($sformatf("%s_bit%0d", tag, p), {30'd0, seen1[p], seen0[p]}, expb[p] ? 32'd2 : 32'd1);
    check({tag, "_bclk_en_cycles"}, bcnt, nsamp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w, ns, zeros;
    logic t0, t1;
    reset = 1'b1; bclk = 1'b1; write_en = 1'b0; data_in = '0; tx_en = 1'b0;
    parity_en = 1'b0; parity_type = 1'b0; tx_thr_val = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_empty", tx_empty, 1);
    check("rst_full", tx_full, 0);
    check("rst_ov", tx_ov, 0);
    check("rst_thr", tx_thr, 1);
    check("rst_bclk_en", tx_bclk_en, 0);
    reset = 1'b0;
    @(negedge clk);

    // Plain frame 0xA5
    tx_en = 1'b1;
    push_byte(8'hA5);
    recv_frame("a5", 0, w, ns, t0, t1);
    check("a5_len", ns, 160 + 16 * (NSTOP - 1));
    check("a5_idle_txd", txd, 1);
    check("a5_idle_bclk_en", tx_bclk_en, 0);

    // Parity odd/even, then settings held for the frame
    parity_en = 1'b1; parity_type = 1'b1;
    push_byte(8'h03);
    recv_frame("par_odd", 0, w, ns, t0, t1);
    check("par_odd_len", ns, 176 + 16 * (NSTOP - 1));
    parity_type = 1'b0;
    push_byte(8'h03);
    recv_frame("par_even", 0, w, ns, t0, t1);
    check("par_even_len", ns, 176 + 16 * (NSTOP - 1));
    parity_type = 1'b1;
    push_byte(8'h5A);
    recv_frame("par_hold", 1, w, ns, t0, t1);
    check("par_hold_len", ns, 176 + 16 * (NSTOP - 1));
    parity_en = 1'b0; parity_type = 1'b0;

    // Fill FIFO, overflow, then drain back-to-back
    tx_en = 1'b0;
    tx_thr_val = 2'd3;
    for (int i = 0; i < 17; i++) begin
      write_en = 1'b1;
      data_in = 8'(i);
      @(negedge clk);
      if (i < 16) sb.push_back('{8'(i), 1'b0, 1'b0});
      if (i == 14) check("full_after15", tx_full, 0);
      if (i == 15) begin
        check("full_after16", tx_full, 1);
        check("ov_after16", tx_ov, 0);
      end
      if (i == 16) check("ov_after17", tx_ov, 1);
    end
    write_en = 1'b0;
    @(negedge clk);
    check("ov_pulse_end", tx_ov, 0);
    check("full_hold", tx_full, 1);
    check("thr_at_full", tx_thr, 0);
    tx_en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      recv_frame($sformatf("fifo%0d", k), 0, w, ns, t0, t1);
      if (k > 0) check($sformatf("fifo%0d_gap", k), w, 0);
    end
    check("fifo_drained", tx_empty, 1);
    check("thr_drained", tx_thr, 1);

    // Two queued bytes: no idle gap, threshold one cycle after last pop
    tx_en = 1'b0;
    tx_thr_val = 2'd0;
    push_byte(8'h3C);
    push_byte(8'hC3);
    @(negedge clk);
    check("thr_two_queued", tx_thr, 0);
    tx_en = 1'b1;
    recv_frame("b2b0", 0, w, ns, t0, t1);
    recv_frame("b2b1", 0, w, ns, t0, t1);
    check("b2b1_gap", w, 0);
    check("b2b1_thr_at_pop", t0, 0);
    check("b2b1_thr_after_pop", t1, 1);

    // tx_en dropped mid-frame: frame completes, nothing new starts
    tx_en = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    tx_en = 1'b1;
    recv_frame("drop", 2, w, ns, t0, t1);
    zeros = 0;
    repeat (40) begin
      if (txd !== 1'b1) zeros++;
      @(negedge clk);
    end
    check("drop_no_start", zeros, 0);
    check("drop_pending", tx_empty, 0);
    tx_en = 1'b1;
    recv_frame("drop_resume", 0, w, ns, t0, t1);

    // Reset during data bit 3 aborts the frame and flushes the FIFO
    tx_en = 1'b0;
    push_byte(8'h00);
    push_byte(8'h00);
    tx_en = 1'b1;
    w = 0;
    while (txd !== 1'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_start_seen", txd, 0);
    repeat (70) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_empty", tx_empty, 1);
    check("rst_mid_bclk_en", tx_bclk_en, 0);
    reset = 1'b0;
    sb.delete();
    zeros = 0;
    repeat (200) begin
      if (txd !== 1'b1) zeros++;
      @(negedge clk);
    end
    check("rst_mid_no_start", zeros, 0);
    check("rst_mid_still_empty", tx_empty, 1);

    // bclk stalled for 20 cycles stretches the frame by 20 cycles
    push_byte(8'h96);
    recv_frame("stall", 3, w, ns, t0, t1);
    check("stall_len", ns, 180 + 16 * (NSTOP - 1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
